seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Downstream display stage of the stopwatch. Consumes the four BCD digits m10, m1, s10 and s1 from the counter.
- Time-multiplexes them onto a 4-digit common-anode seven-segment display (all outputs active-low).
- In adjust mode, blinks the digit pair currently selected for adjustment.
- Runs on the fast display clock, alongside the button debouncing logic.

Parameters:
- SCAN_DIV, 50000, clkDis cycles each digit is held before the scan advances to the next digit (>=2).
- BLINK_DIV, 12500000, clkDis cycles per blink half-period (>=2).

Ports:
- clkDis  input  1  display clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- m10  input  3  minutes tens digit, 0-5 expected.
- m1  input  4  minutes ones digit, 0-9 expected.
- s10  input  3  seconds tens digit, 0-5 expected.
- s1  input  4  seconds ones digit, 0-9 expected.
- adj  input  1  adjust mode active; enables blinking.
- sel  input  1  adjust target: 1 = seconds pair, 0 = minutes pair.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anodes, active-low. an[0]=s1, an[1]=s10, an[2]=m1, an[3]=m10.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - scanCnt=0, digit index idx=0, blinkCnt=0, blinkOn=1.
- Scan counter:
  - scanCnt counts 0..SCAN_DIV-1 and wraps.
  - On the wrap cycle, idx advances 0->1->2->3->0.
- Output registers:
  - seg, an and dp are registered and update together.
  - They reflect idx and the current digit input one clkDis cycle after idx changes; they never reflect a mix of two digits.
  - First cycle after reset release: outputs still all-off. From the second cycle: digit 0 (s1) is shown.
- Anode: exactly one an bit is low at a time, except when the digit is blanked (all an high, seg all high).
- Digit source by idx: 0=s1, 1=s10 (zero-extended to 4 bits), 2=m1, 3=m10 (zero-extended).
- Inputs are sampled combinationally at the output-register clock edge. A counter change mid-scan appears the next time that digit is scanned.
- Decode (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10-15: dash, 0111111.
- dp: low (lit) only when idx=2, as the minutes/seconds separator; otherwise high.
  - dp is high whenever the digit is blanked.
- Blink:
  - blinkCnt counts 0..BLINK_DIV-1; blinkOn toggles on wrap.
  - A rising edge of adj (registered previous value) clears blinkCnt and sets blinkOn=1, so the pair is visible immediately on entering adjust.
- Blanking:
  - When adj=1 and blinkOn=0, digits in the selected pair are blanked: idx 0,1 if sel=1; idx 2,3 if sel=0.
  - The other pair displays normally.
  - adj=0: no blanking, regardless of blinkOn.
- sel change while adj=1: takes effect from the next output update; blink phase is not disturbed.
- Simultaneous scan wrap and blink wrap: both take effect. The new blinkOn applies from the following output update.
- Reset asserted mid-scan: all outputs go off immediately (asynchronous). After release, scanning restarts at idx 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when idx=3 and m10==0, the digit is blanked (an[3] stays high, seg all high) in all modes. Blink logic is unaffected for the other digits.
- Undefined: m10=0 displays "0" (seg=1000000).

Test Plan:
- SCAN_DIV=4. Reset, release, inputs m10=1, m1=2, s10=3, s1=4:
  - an sequence 1110,1101,1011,0111, each held 4 cycles.
  - seg 0011001, 0110000, 0100100, 1111001 respectively.
  - dp=0 only with an=1011.
- Reset asserted mid-digit: an=1111, seg=1111111 the same cycle without a clock edge. After release, first lit anode is an=1110.
- SCAN_DIV=4, BLINK_DIV=8, adj=1, sel=1:
  - Anodes 1110/1101 are visible for 8 cycles after the adj rise, then fully blank for 8 cycles.
  - Anodes 1011/0111 are never blanked.
  - With sel=0 the roles swap.
- s1=4'd12: digit 0 shows dash 0111111. m10=3'd7: digit 3 shows 1111000.
- m10=0: the idx=3 digit shows 1000000 without the macro; with LEADING_ZERO_BLANK_EN, an stays 1111 and seg stays 1111111 during the idx=3 slot.
- s1 changes 4->5 while idx=2: digit 0 shows 0010010 on its next slot, never a partial update.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexes m10/m1/s10/s1 onto a 4-digit common-anode display; seg/an/dp registered, one clkDis behind idx.
// Adjust mode blinks the selected pair; LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit. Free-running, no backpressure.
module seven_seg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clkDis,
  input  logic       rst,
  input  logic [2:0] m10,
  input  logic [3:0] m1,
  input  logic [2:0] s10,
  input  logic [3:0] s1,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE   = SW'(1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  logic [SW-1:0] scanCnt;
  logic [BW-1:0] blinkCnt;
  logic [1:0]    idx;
  logic          blinkOn;
  logic          adjQ;

  logic          adjRise;
  logic          scanWrap;
  logic          blinkWrap;
  logic          inPair;
  logic          blinkBlank;
  logic          lzBlank;
  logic          blank;
  logic [3:0]    digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign adjRise   = adj & ~adjQ;
  assign scanWrap  = (scanCnt == SCAN_LAST);
  assign blinkWrap = (blinkCnt == BLINK_LAST);

  // seconds pair is idx 0/1, minutes pair idx 2/3; the rising adj edge counts as visible
  assign inPair     = sel ? ~idx[1] : idx[1];
  assign blinkBlank = adj & ~(blinkOn | adjRise) & inPair;

`ifdef LEADING_ZERO_BLANK_EN
  assign lzBlank = (idx == 2'd3) && (m10 == 3'd0);
`else
  assign lzBlank = 1'b0;
`endif

  assign blank = blinkBlank | lzBlank;

  always_comb begin
    digit = s1;
    case (idx)
      2'd0:    digit = s1;
      2'd1:    digit = {1'b0, s10};
      2'd2:    digit = m1;
      default: digit = {1'b0, m10};
    endcase
  end

  always_ff @(posedge clkDis or negedge rst) begin
    if (!rst) begin
      scanCnt  <= '0;
      idx      <= 2'd0;
      blinkCnt <= '0;
      blinkOn  <= 1'b1;
      adjQ     <= 1'b0;
      an       <= 4'b1111;
      seg      <= 7'b1111111;
      dp       <= 1'b1;
    end else begin
      adjQ <= adj;

      if (scanWrap) begin
        scanCnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        scanCnt <= scanCnt + SCAN_ONE;
      end

      if (adjRise) begin
        blinkCnt <= '0;
        blinkOn  <= 1'b1;
      end else if (blinkWrap) begin
        blinkCnt <= '0;
        blinkOn  <= ~blinkOn;
      end else begin
        blinkCnt <= blinkCnt + BLINK_ONE;
      end

      // all three outputs load from the same idx so a digit is never mixed with its neighbour
      if (blank) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= decode(digit);
        dp  <= (idx != 2'd2);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with SCAN_DIV=4, BLINK_DIV=8: a cycle model pushes expected outputs, scenario tasks pop and compare.
module tb_seven_seg_scan;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  logic       clkDis = 1'b0;
  logic       rst    = 1'b1;
  logic [2:0] m10    = 3'd0;
  logic [3:0] m1     = 4'd0;
  logic [2:0] s10    = 3'd0;
  logic [3:0] s1     = 4'd0;
  logic       adj    = 1'b0;
  logic       sel    = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  disp_t exp_q[$];

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  logic [3:0] an_of [4]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seven_seg_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clkDis(clkDis), .rst(rst), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .adj(adj), .sel(sel), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clkDis = ~clkDis;

  // cycle model: state before each edge decides what the output register holds after it
  int   m_scan, m_idx, m_bcnt;
  logic m_bon, m_adjq;

  always @(posedge clkDis or negedge rst) begin
    if (!rst) begin
      m_scan = 0; m_idx = 0; m_bcnt = 0; m_bon = 1'b1; m_adjq = 1'b0;
      exp_q.delete();
    end else begin
      disp_t e;
      logic [3:0] d;
      logic rise, pair, blanked;
      rise = adj && !m_adjq;
      pair = sel ? (m_idx < 2) : (m_idx >= 2);
      blanked = adj && !(m_bon || rise) && pair;
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx == 3 && m10 == 3'd0) blanked = 1'b1;
`endif
      case (m_idx)
        0: d = s1;
        1: d = {1'b0, s10};
        2: d = m1;
        default: d = {1'b0, m10};
      endcase
      if (blanked) e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
      else e = '{an: an_of[m_idx], seg: seg_tab[d], dp: (m_idx == 2) ? 1'b0 : 1'b1};
      exp_q.push_back(e);
      m_adjq = adj;
      if (rise) begin m_bcnt = 0; m_bon = 1'b1; end
      else if (m_bcnt == BLINK_DIV - 1) begin m_bcnt = 0; m_bon = !m_bon; end
      else m_bcnt = m_bcnt + 1;
      if (m_scan == SCAN_DIV - 1) begin m_scan = 0; m_idx = (m_idx + 1) % 4; end
      else m_scan = m_scan + 1;
    end
  end

  task automatic do_reset();
    @(negedge clkDis);
    rst = 1'b0;
    @(negedge clkDis);
    rst = 1'b1;
  endtask

  task automatic skip(input int n);
    repeat (n) begin
      @(negedge clkDis);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    disp_t e;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    nchk++; if (an !== 4'b1111) begin nerr++; $display("FAIL reset_an: got %b want 1111", an); end
    nchk++; if (seg !== 7'b1111111) begin nerr++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    nchk++; if (dp !== 1'b1) begin nerr++; $display("FAIL reset_dp: got %b want 1", dp); end
    m10 = 3'd1; m1 = 4'd2; s10 = 3'd3; s1 = 4'd4;
    @(negedge clkDis);
    @(negedge clkDis);
    rst = 1'b1;
    #1;
    nchk++; if ({an, seg, dp} !== 12'hFFF) begin nerr++; $display("FAIL release_off: got an=%b seg=%b dp=%b want all off", an, seg, dp); end
    @(negedge clkDis);
    nchk++;
    if (exp_q.size() == 0) begin nerr++; $display("FAIL reset_sb: no expected entry, got an=%b", an); end
    else begin
      e = exp_q.pop_front();
      if ({an, seg, dp} !== e) begin nerr++; $display("FAIL reset_sb: got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp); end
    end
    nchk++; if (an !== 4'b1110) begin nerr++; $display("FAIL reset_first_an: got %b want 1110", an); end
  endtask

  task automatic test_scan();
    disp_t e;
    logic [6:0] want_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    m10 = 3'd1; m1 = 4'd2; s10 = 3'd3; s1 = 4'd4; adj = 1'b0; sel = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clkDis);
      nchk++;
      if (exp_q.size() == 0) begin nerr++; $display("FAIL scan_sb: no expected entry, got an=%b", an); end
      else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin nerr++; $display("FAIL scan_sb: got %b/%b/%b want %b/%b/%b", an, seg, dp, e.an, e.seg, e.dp); end
      end
      nchk++;
      if ({an, seg, dp} !== {an_of[k/4], want_seg[k/4], (k/4 == 2) ? 1'b0 : 1'b1}) begin
        nerr++; $display("FAIL scan_seq[%0d]: got %b/%b/%b want %b/%b/%b", k, an, seg, dp, an_of[k/4], want_seg[k/4], (k/4 == 2) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_reset_mid();
    skip(6);
    @(negedge clkDis);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    #2 rst = 1'b0;
    #1;
    nchk++; if ({an, seg, dp} !== 12'hFFF) begin nerr++; $display("FAIL midreset_off: got an=%b seg=%b dp=%b want all off", an, seg, dp); end
    @(negedge clkDis);
    rst = 1'b1;
    @(negedge clkDis);
    nchk++; if (an !== 4'b1110) begin nerr++; $display("FAIL midreset_first_an: got %b want 1110", an); end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_blink(input logic sel_v);
    disp_t e;
    logic [3:0] b0, b1;
    b0 = sel_v ? 4'b1110 : 4'b1011;
    b1 = sel_v ? 4'b1101 : 4'b0111;
    m10 = 3'd1; m1 = 4'd2; s10 = 3'd3; s1 = 4'd4; adj = 1'b0; sel = sel_v;
    do_reset();
    skip(5);
    adj = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clkDis);
      nchk++;
      if (exp_q.size() == 0) begin nerr++; $display("FAIL blink_sb: no expected entry, got an=%b", an); end
      else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin nerr++; $display("FAIL blink_sb[%0d] sel=%b: got %b/%b/%b want %b/%b/%b", k, sel_v, an, seg, dp, e.an, e.seg, e.dp); end
      end
      if (k >= 1 && k <= 8) begin
        nchk++; if (an === 4'b1111) begin nerr++; $display("FAIL blink_visible[%0d] sel=%b: got an=%b want a lit digit", k, sel_v, an); end
      end
      if (k >= 9 && k <= 16) begin
        nchk++; if (an === b0 || an === b1) begin nerr++; $display("FAIL blink_hidden[%0d] sel=%b: got an=%b want pair blanked", k, sel_v, an); end
      end
    end
  endtask

  task automatic test_sel_adj_change();
    disp_t e;
    for (int k = 0; k < 48; k++) begin
      @(negedge clkDis);
      if (k == 5)  sel = ~sel;
      if (k == 30) adj = 1'b0;
      nchk++;
      if (exp_q.size() == 0) begin nerr++; $display("FAIL selchg_sb: no expected entry, got an=%b", an); end
      else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin nerr++; $display("FAIL selchg_sb[%0d]: got %b/%b/%b want %b/%b/%b", k, an, seg, dp, e.an, e.seg, e.dp); end
      end
      if (k >= 32) begin
        nchk++; if (an === 4'b1111) begin nerr++; $display("FAIL adj_off_noblank[%0d]: got an=1111 want lit digit", k); end
      end
    end
  endtask

  task automatic test_decode();
    disp_t e;
    m10 = 3'd7; m1 = 4'd9; s10 = 3'd0; s1 = 4'd12; adj = 1'b0; sel = 1'b0;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      @(negedge clkDis);
      if (k == 16) m10 = 3'd0;
      nchk++;
      if (exp_q.size() == 0) begin nerr++; $display("FAIL decode_sb: no expected entry, got an=%b", an); end
      else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin nerr++; $display("FAIL decode_sb[%0d]: got %b/%b/%b want %b/%b/%b", k, an, seg, dp, e.an, e.seg, e.dp); end
      end
      if (an === 4'b1110) begin
        nchk++; if (seg !== 7'b0111111) begin nerr++; $display("FAIL decode_dash: got %b want 0111111", seg); end
      end
      if (k < 16 && an === 4'b0111) begin
        nchk++; if (seg !== 7'b1111000) begin nerr++; $display("FAIL decode_m10_7: got %b want 1111000", seg); end
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (k >= 20) begin
        nchk++; if (an === 4'b0111) begin nerr++; $display("FAIL lzb_blank: got an=%b seg=%b want idx3 blanked", an, seg); end
      end
`else
      if (k >= 20 && an === 4'b0111) begin
        nchk++; if (seg !== 7'b1000000) begin nerr++; $display("FAIL m10_zero: got %b want 1000000", seg); end
      end
`endif
    end
  endtask

  task automatic test_midscan_update();
    disp_t e;
    int stage;
    m10 = 3'd1; m1 = 4'd2; s10 = 3'd3; s1 = 4'd4; adj = 1'b0; sel = 1'b0;
    do_reset();
    stage = 0;
    for (int k = 0; k < 60 && stage < 2; k++) begin
      @(negedge clkDis);
      nchk++;
      if (exp_q.size() == 0) begin nerr++; $display("FAIL midscan_sb: no expected entry, got an=%b", an); end
      else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin nerr++; $display("FAIL midscan_sb[%0d]: got %b/%b/%b want %b/%b/%b", k, an, seg, dp, e.an, e.seg, e.dp); end
      end
      if (stage == 0 && an === 4'b1011) begin
        s1 = 4'd5;
        stage = 1;
      end else if (stage == 1 && an === 4'b1110) begin
        nchk++; if (seg !== 7'b0010010) begin nerr++; $display("FAIL midscan_new_s1: got %b want 0010010", seg); end
        stage = 2;
      end
    end
    nchk++; if (stage != 2) begin nerr++; $display("FAIL midscan_timeout: reached stage %0d want 2", stage); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_reset_mid();
    test_blink(1'b1);
    test_blink(1'b0);
    test_sel_adj_change();
    test_decode();
    test_midscan_update();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
